// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD display path: digit width,
// converter states and the overflow threshold helper.
package bin2bcd_seq_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value representable in the given number of BCD digits.
    function automatic int unsigned bcd_max(input int digits);
        int unsigned m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single BCD digit correction for double dabble: add 3 when the digit is 5 or more.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done
// handshake, saturating to all 9s when the input exceeds the digit range.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3 + shift per cycle, BIN_W iterations
// DONE  | result valid, done pulse; returns to IDLE
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_shift;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               ovf_final;
    logic               ovf_in;
    logic               accept;
    logic               last_shift;
    logic               busy_nxt;
    logic               done_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
            .digit_out (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign scratch_shift = {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    assign ovf_in        = 32'(bin_in) > bcd_max(DIGITS);
    // A carry out of the top digit can only happen for out-of-range values.
    assign ovf_final     = ovf_pend | adj[BCD_W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept     = (state == IDLE) && start;
        last_shift = (state == SHIFT) && (cnt == CNT_W'(1));
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state_nxt == DONE);
    end

    // Outputs are loaded on the edge entering DONE so they are valid with the done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (accept) begin
                bin_sr   <= bin_in;
                scratch  <= '0;
                cnt      <= CNT_W'(BIN_W);
                ovf_pend <= ovf_in;
            end else if (state == SHIFT) begin
                bin_sr   <= {bin_sr[BIN_W-2:0], 1'b0};
                scratch  <= scratch_shift;
                cnt      <= cnt - CNT_W'(1);
                ovf_pend <= ovf_final;
            end
            if (last_shift) begin
                overflow <= ovf_final;
                bcd_out  <= ovf_final ? ALL_NINES : scratch_shift;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle-level reference model plus
// literal expectations on each conversion result.
module tb_bin2bcd_seq;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int LATENCY = BIN_W + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int checks;
    int passed;

    // reference model state
    int          m_age;
    int          m_val;
    logic [15:0] m_bcd;
    logic        m_ovf;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        if (v > 9999) return 16'h9999;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Model: m_age counts cycles since a start was accepted; done in the last one.
    always @(posedge clk) begin
        if (!rst) begin
            m_age = 0;
            m_bcd = '0;
            m_ovf = 1'b0;
        end else if (m_age == LATENCY) begin
            m_age = 0;
        end else if (m_age > 0) begin
            m_age = m_age + 1;
            if (m_age == LATENCY) begin
                m_bcd = to_bcd(m_val);
                m_ovf = (m_val > 9999);
            end
        end else if (start) begin
            m_age = 1;
            m_val = int'(bin_in);
        end
    end

    always @(negedge clk) begin
        check("busy",     int'(busy),     int'(m_age != 0));
        check("done",     int'(done),     int'(m_age == LATENCY));
        check("bcd_out",  int'(bcd_out),  int'(m_bcd));
        check("overflow", int'(overflow), int'(m_ovf));
    end

    // Pulse start for one cycle, wait for done, check result and latency.
    task automatic convert(input int value, input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        @(negedge clk);
        bin_in = 14'(value);
        start  = 1'b1;
        n = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start  = 1'b0;
            bin_in = 14'h3fff ^ 14'(value);
            if (done) break;
            if (n > 40) begin
                check("done_timeout", n, LATENCY);
                return;
            end
        end
        check("latency",  n, LATENCY);
        check("lit_bcd",  int'(bcd_out),  int'(exp_bcd));
        check("lit_ovf",  int'(overflow), int'(exp_ovf));
    endtask

    initial begin
        int n;
        checks = 0;
        passed = 0;
        m_age  = 0;
        m_val  = 0;
        m_bcd  = '0;
        m_ovf  = 1'b0;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bcd",  int'(bcd_out), 0);
        check("rst_ovf",  int'(overflow), 0);
        rst = 1'b1;

        convert(0,     16'h0000, 1'b0);
        convert(1234,  16'h1234, 1'b0);
        convert(9999,  16'h9999, 1'b0);
        convert(16383, 16'h9999, 1'b1);
        convert(10000, 16'h9999, 1'b1);
        convert(42,    16'h0042, 1'b0);

        // start held high: one conversion per IDLE entry, input changes ignored while busy
        @(negedge clk);
        bin_in = 14'd7;
        start  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) bin_in = 14'd8;
        end while (!done && n < 40);
        check("held_first", int'(bcd_out), 16'h0007);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        check("held_second", int'(bcd_out), 16'h0008);
        check("held_gap", n, LATENCY + 1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-conversion discards the result
        bin_in = 14'd5678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_bcd",  int'(bcd_out), 0);
        rst = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midrst_no_done", n, 0);
        convert(5678, 16'h5678, 1'b0);

        convert(9,    16'h0009, 1'b0);
        convert(10,   16'h0010, 1'b0);
        convert(99,   16'h0099, 1'b0);
        convert(100,  16'h0100, 1'b0);
        convert(999,  16'h0999, 1'b0);
        convert(1000, 16'h1000, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
